mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_if.sv | 55 +++++
 rtl/mem_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the CPU inst/data handshake ports and the downstream memory port.
//   slave  : arbiter view (requests and memory responses in; accepts, data returns
//            and the downstream request out)
//   master : environment view (CPU requesters and memory bridge)
interface mem_req_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Instruction-fetch requester
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;

  // Load/store requester
  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [2:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  // Downstream bridge port
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wstrb;
  logic [2:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and the
// load/store requesters. Data wins by default; a starvation guard hands the
// port to inst after STARVE_LIMIT consecutive data wins, and a grant lock holds
// the selection until the address is accepted. An in-order FIFO of source IDs
// (0 = inst, 1 = data) routes each data return back to its requester.
//
// Ports:
//   clk     : clock
//   resetn  : asynchronous active-low reset; all outputs are 0 while low
//   bus     : mem_req_arbiter_if.slave (inst_*, data_*, mem_* handshakes)
//   arb_err : sticky protocol-error flag, present only with ARB_ERR_EN defined
//
// Optional feature macro: ARB_ERR_EN
module mem_req_arbiter #(
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             resetn,
  mem_req_arbiter_if.slave bus
`ifdef ARB_ERR_EN
  ,
  output logic             arb_err
`endif
);

  localparam int unsigned PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW       = $clog2(MAX_OUT + 1);
  localparam int unsigned SW       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit          GUARD_EN = (STARVE_LIMIT != 0);

  logic [MAX_OUT-1:0] r_fifo;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_lock_valid;
  logic               r_lock_src;
  logic [SW-1:0]      r_starve_cnt;

  logic w_lock_req;
  logic w_starved;
  logic w_sel;
  logic w_full;
  logic w_mem_req;
  logic w_accept;
  logic w_pop;
  logic w_head;

  assign w_lock_req = r_lock_src ? bus.data_req : bus.inst_req;
  assign w_starved  = GUARD_EN && (r_starve_cnt == SW'(STARVE_LIMIT)) && bus.inst_req;

  // Winner select: honoured lock, then starvation guard, then data over inst
  always_comb begin
    w_sel = 1'b0;
    if (r_lock_valid && w_lock_req) begin
      w_sel = r_lock_src;
    end else if (w_starved) begin
      w_sel = 1'b0;
    end else begin
      w_sel = bus.data_req;
    end
  end

  // A slot freed by a same-cycle pop is not offered until the next cycle
  assign w_full    = (r_count == CW'(MAX_OUT));
  assign w_mem_req = resetn & (bus.inst_req | bus.data_req) & ~w_full;
  assign w_accept  = w_mem_req & bus.mem_addr_ok;
  assign w_pop     = resetn & bus.mem_data_ok & (r_count != '0);
  assign w_head    = r_fifo[r_rptr];

  // Downstream request mux; inst side is always a word read
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_wr    = resetn & w_sel & bus.data_wr;
  assign bus.mem_wstrb = (resetn & w_sel) ? bus.data_wstrb : 4'd0;
  assign bus.mem_size  = !resetn ? 3'd0 : (w_sel ? bus.data_size : 3'd2);
  assign bus.mem_addr  = !resetn ? 32'd0 : (w_sel ? bus.data_addr : bus.inst_addr);
  assign bus.mem_wdata = (resetn & w_sel) ? bus.data_wdata : 32'd0;

  // Zero-cycle accept pass-through and in-order return routing
  assign bus.inst_addr_ok = w_accept & ~w_sel;
  assign bus.data_addr_ok = w_accept & w_sel;
  assign bus.inst_data_ok = w_pop & ~w_head;
  assign bus.data_data_ok = w_pop & w_head;
  assign bus.inst_rdata   = resetn ? bus.mem_rdata : 32'd0;
  assign bus.data_rdata   = resetn ? bus.mem_rdata : 32'd0;

  // Source-ID FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Grant lock; a lock whose owner dropped req is released at this edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock_valid <= 1'b0;
      r_lock_src   <= 1'b0;
    end else if (bus.mem_addr_ok) begin
      r_lock_valid <= 1'b0;
    end else if (w_mem_req) begin
      r_lock_valid <= 1'b1;
      r_lock_src   <= w_sel;
    end else if (r_lock_valid && !w_lock_req) begin
      r_lock_valid <= 1'b0;
    end
  end

  // Consecutive data wins while inst waits, saturating at the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!bus.inst_req) begin
      r_starve_cnt <= '0;
    end else if (w_accept && !w_sel) begin
      r_starve_cnt <= '0;
    end else if (w_accept && w_sel && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

`ifdef ARB_ERR_EN
  logic r_arb_err;

  // Sticky: stray data return, or locked requester abandoning its request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_arb_err <= 1'b0;
    end else if ((bus.mem_data_ok && (r_count == '0)) || (r_lock_valid && !w_lock_req)) begin
      r_arb_err <= 1'b1;
    end
  end

  assign arb_err = r_arb_err;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic checked
// each cycle against a queue-based reference model.
module tb_mem_req_arbiter;
  localparam int unsigned MAX_OUT      = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic resetn;
`ifdef ARB_ERR_EN
  logic arb_err;
`endif

  mem_req_arbiter_if u_if ();

  mem_req_arbiter #(
    .MAX_OUT      (MAX_OUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if.slave)
`ifdef ARB_ERR_EN
    ,
    .arb_err(arb_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit mq[$];
  bit m_lock_v, m_lock_src, m_err;
  int m_starve;
  bit last_inst_acc, last_data_acc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    u_if.inst_req    = 1'b0;
    u_if.inst_addr   = 32'd0;
    u_if.data_req    = 1'b0;
    u_if.data_wr     = 1'b0;
    u_if.data_wstrb  = 4'd0;
    u_if.data_size   = 3'd0;
    u_if.data_addr   = 32'd0;
    u_if.data_wdata  = 32'd0;
    u_if.mem_addr_ok = 1'b0;
    u_if.mem_data_ok = 1'b0;
    u_if.mem_rdata   = 32'd0;
  endtask

  // Called just after a falling edge with inputs already driven: compare all
  // outputs with the model, advance the model, move to the next falling edge.
  task automatic cycle();
    bit lreq, sel, mreq, acc, pop, head;
    int sz;
    #2;
    lreq = m_lock_src ? u_if.data_req : u_if.inst_req;
    if (m_lock_v && lreq)                                               sel = m_lock_src;
    else if (STARVE_LIMIT != 0 && m_starve == STARVE_LIMIT && u_if.inst_req) sel = 1'b0;
    else                                                                sel = u_if.data_req;
    sz   = mq.size();
    mreq = (u_if.inst_req || u_if.data_req) && (sz < MAX_OUT);
    acc  = mreq && u_if.mem_addr_ok;
    pop  = u_if.mem_data_ok && (sz != 0);
    head = pop ? mq[0] : 1'b0;

    check_val("mem_req",      32'(u_if.mem_req),      32'(mreq));
    check_val("mem_addr",     u_if.mem_addr,          sel ? u_if.data_addr : u_if.inst_addr);
    check_val("mem_wr",       32'(u_if.mem_wr),       32'(sel & u_if.data_wr));
    check_val("mem_wstrb",    32'(u_if.mem_wstrb),    sel ? 32'(u_if.data_wstrb) : 32'd0);
    check_val("mem_size",     32'(u_if.mem_size),     sel ? 32'(u_if.data_size) : 32'd2);
    check_val("mem_wdata",    u_if.mem_wdata,         sel ? u_if.data_wdata : 32'd0);
    check_val("inst_addr_ok", 32'(u_if.inst_addr_ok), 32'(acc && !sel));
    check_val("data_addr_ok", 32'(u_if.data_addr_ok), 32'(acc && sel));
    check_val("inst_data_ok", 32'(u_if.inst_data_ok), 32'(pop && !head));
    check_val("data_data_ok", 32'(u_if.data_data_ok), 32'(pop && head));
    check_val("inst_rdata",   u_if.inst_rdata,        u_if.mem_rdata);
    check_val("data_rdata",   u_if.data_rdata,        u_if.mem_rdata);
`ifdef ARB_ERR_EN
    check_val("arb_err",      32'(arb_err),           32'(m_err));
    if ((u_if.mem_data_ok && sz == 0) || (m_lock_v && !lreq)) m_err = 1'b1;
`endif
    last_inst_acc = acc && !sel;
    last_data_acc = acc && sel;
    if (acc) mq.push_back(sel);
    if (pop) void'(mq.pop_front());
    if (u_if.mem_addr_ok) m_lock_v = 1'b0;
    else if (mreq) begin
      m_lock_v   = 1'b1;
      m_lock_src = sel;
    end else if (m_lock_v && !lreq) m_lock_v = 1'b0;
    if (!u_if.inst_req) m_starve = 0;
    else if (acc && !sel) m_starve = 0;
    else if (acc && sel && m_starve < int'(STARVE_LIMIT)) m_starve++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset with busy inputs, check every output is 0, then release
  task automatic do_reset();
    resetn           = 1'b0;
    u_if.inst_req    = 1'b1;
    u_if.inst_addr   = 32'hBFC0_0000;
    u_if.data_req    = 1'b1;
    u_if.data_wr     = 1'b1;
    u_if.data_wstrb  = 4'hF;
    u_if.data_size   = 3'd2;
    u_if.data_addr   = 32'h8000_0000;
    u_if.data_wdata  = 32'h1234_5678;
    u_if.mem_addr_ok = 1'b1;
    u_if.mem_data_ok = 1'b1;
    u_if.mem_rdata   = 32'hDEAD_BEEF;
    #1;
    check_val("rst mem_req",      32'(u_if.mem_req),      32'd0);
    check_val("rst mem_wr",       32'(u_if.mem_wr),       32'd0);
    check_val("rst mem_wstrb",    32'(u_if.mem_wstrb),    32'd0);
    check_val("rst mem_size",     32'(u_if.mem_size),     32'd0);
    check_val("rst mem_addr",     u_if.mem_addr,          32'd0);
    check_val("rst mem_wdata",    u_if.mem_wdata,         32'd0);
    check_val("rst inst_addr_ok", 32'(u_if.inst_addr_ok), 32'd0);
    check_val("rst data_addr_ok", 32'(u_if.data_addr_ok), 32'd0);
    check_val("rst inst_data_ok", 32'(u_if.inst_data_ok), 32'd0);
    check_val("rst data_data_ok", 32'(u_if.data_data_ok), 32'd0);
    check_val("rst inst_rdata",   u_if.inst_rdata,        32'd0);
    check_val("rst data_rdata",   u_if.data_rdata,        32'd0);
`ifdef ARB_ERR_EN
    check_val("rst arb_err",      32'(arb_err),           32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    set_idle();
    mq.delete();
    m_lock_v = 1'b0; m_lock_src = 1'b0; m_err = 1'b0; m_starve = 0;
    last_inst_acc = 1'b0; last_data_acc = 1'b0;
    resetn = 1'b1;
  endtask

  // Return all outstanding data with no new requests
  task automatic drain();
    set_idle();
    for (int k = 0; k < int'(2 * MAX_OUT) && mq.size() != 0; k++) begin
      u_if.mem_data_ok = 1'b1;
      u_if.mem_rdata   = $urandom();
      cycle();
    end
    u_if.mem_data_ok = 1'b0;
    check_val("drain empty", 32'(mq.size()), 32'd0);
  endtask

  task automatic random_traffic(input int n_cycles);
    for (int n = 0; n < n_cycles; n++) begin
      if (u_if.inst_req && !last_inst_acc) begin
        if ($urandom_range(0, 31) == 0) u_if.inst_req = 1'b0;
      end else begin
        u_if.inst_req  = ($urandom_range(0, 2) != 0);
        u_if.inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (u_if.data_req && !last_data_acc) begin
        if ($urandom_range(0, 31) == 0) u_if.data_req = 1'b0;
      end else begin
        u_if.data_req   = ($urandom_range(0, 2) != 0);
        u_if.data_wr    = 1'($urandom_range(0, 1));
        u_if.data_wstrb = 4'($urandom());
        u_if.data_size  = 3'($urandom_range(0, 2));
        u_if.data_addr  = $urandom();
        u_if.data_wdata = $urandom();
      end
      u_if.mem_addr_ok = ($urandom_range(0, 3) != 0);
      u_if.mem_data_ok = (mq.size() != 0) ? ($urandom_range(0, 2) != 0)
                                          : ($urandom_range(0, 15) == 0);
      u_if.mem_rdata   = $urandom();
      cycle();
    end
  endtask

  initial begin
    bit ids[$];
    set_idle();
    resetn = 1'b1;
    #1;
    do_reset();

    // Same-cycle contention: data wins, inst follows; returns in order
    u_if.inst_req = 1'b1; u_if.inst_addr = 32'hBFC0_0000;
    u_if.data_req = 1'b1; u_if.data_wr = 1'b0; u_if.data_size = 3'd2;
    u_if.data_addr = 32'h8000_1000; u_if.mem_addr_ok = 1'b1;
    #1;
    check_val("t1 mem_addr data", u_if.mem_addr, 32'h8000_1000);
    check_val("t1 data_addr_ok",  32'(u_if.data_addr_ok), 32'd1);
    check_val("t1 inst held off", 32'(u_if.inst_addr_ok), 32'd0);
    cycle();
    u_if.data_req = 1'b0;
    #1;
    check_val("t1 mem_addr inst", u_if.mem_addr, 32'hBFC0_0000);
    check_val("t1 inst_addr_ok",  32'(u_if.inst_addr_ok), 32'd1);
    cycle();
    u_if.inst_req = 1'b0; u_if.mem_addr_ok = 1'b0;
    u_if.mem_data_ok = 1'b1; u_if.mem_rdata = 32'h11;
    #1;
    check_val("t1 data_data_ok first", 32'(u_if.data_data_ok), 32'd1);
    check_val("t1 data_rdata",         u_if.data_rdata, 32'h11);
    check_val("t1 inst_data_ok first", 32'(u_if.inst_data_ok), 32'd0);
    cycle();
    u_if.mem_rdata = 32'h22;
    #1;
    check_val("t1 inst_data_ok second", 32'(u_if.inst_data_ok), 32'd1);
    check_val("t1 inst_rdata",          u_if.inst_rdata, 32'h22);
    cycle();
    drain();

    // Starvation guard: 8 data accepts, 9th goes to inst, then data again
    cycle();
    u_if.inst_req = 1'b1; u_if.inst_addr = 32'hBFC0_0040;
    u_if.data_req = 1'b1; u_if.data_addr = 32'h8000_2000;
    u_if.mem_addr_ok = 1'b1;
    for (int k = 1; k <= int'(STARVE_LIMIT) + 2; k++) begin
      u_if.mem_data_ok = (mq.size() != 0);
      #1;
      if (k == int'(STARVE_LIMIT) + 1)
        check_val("t2 inst after starve", 32'(u_if.inst_addr_ok), 32'd1);
      else
        check_val("t2 data wins", 32'(u_if.data_addr_ok), 32'd1);
      cycle();
    end
    drain();

    // Grant lock holds inst while mem stalls and data arrives
    u_if.inst_req = 1'b1; u_if.inst_addr = 32'hBFC0_0100;
    for (int k = 1; k <= 5; k++) begin
      if (k >= 2) begin
        u_if.data_req = 1'b1; u_if.data_addr = 32'h8000_3000;
      end
      u_if.mem_addr_ok = (k >= 4);
      if (k == 5) u_if.inst_req = 1'b0;
      #1;
      if (k <= 4) check_val("t3 mem_addr locked", u_if.mem_addr, 32'hBFC0_0100);
      if (k == 4) check_val("t3 inst accept", 32'(u_if.inst_addr_ok), 32'd1);
      if (k == 5) check_val("t3 data accept", 32'(u_if.data_addr_ok), 32'd1);
      cycle();
    end
    drain();

    // Full FIFO blocks mem_req; a pop reopens it only on the next cycle
    u_if.inst_req = 1'b1; u_if.data_req = 1'b1; u_if.mem_addr_ok = 1'b1;
    for (int k = 0; k < int'(MAX_OUT); k++) cycle();
    #1;
    check_val("t4 full mem_req", 32'(u_if.mem_req), 32'd0);
    cycle();
    u_if.mem_data_ok = 1'b1;
    #1;
    check_val("t4 pop no bypass", 32'(u_if.mem_req), 32'd0);
    cycle();
    u_if.mem_data_ok = 1'b0;
    #1;
    check_val("t4 reopened", 32'(u_if.mem_req), 32'd1);
    cycle();
    drain();

    // Push+pop at count 2 across pointer wrap keeps ID order
    u_if.data_req = 1'b1; u_if.mem_addr_ok = 1'b1;
    cycle(); cycle();
    ids = '{1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      u_if.inst_req = (i % 2 == 0); u_if.data_req = (i % 2 == 1);
      u_if.mem_data_ok = 1'b1; u_if.mem_rdata = 32'(i);
      #1;
      check_val("t5 mem_req", 32'(u_if.mem_req), 32'd1);
      check_val("t5 data_data_ok", 32'(u_if.data_data_ok), 32'(ids[0]));
      check_val("t5 inst_data_ok", 32'(u_if.inst_data_ok), 32'(!ids[0]));
      cycle();
      void'(ids.pop_front());
      ids.push_back(i % 2 == 1);
    end
    check_val("t5 count kept", 32'(mq.size()), 32'd2);
    drain();

`ifdef ARB_ERR_EN
    // Stray data return: dropped, flags a sticky error until reset
    check_val("t6 err clear", 32'(arb_err), 32'd0);
    u_if.mem_data_ok = 1'b1;
    #1;
    check_val("t6 no inst_data_ok", 32'(u_if.inst_data_ok), 32'd0);
    check_val("t6 no data_data_ok", 32'(u_if.data_data_ok), 32'd0);
    cycle();
    u_if.mem_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("t6 err sticky", 32'(arb_err), 32'd1);
      cycle();
    end
    do_reset();
    #1;
    check_val("t6 err after reset", 32'(arb_err), 32'd0);
    @(negedge clk);
`endif

    random_traffic(1500);
    // Reset mid-traffic discards outstanding IDs
    do_reset();
    random_traffic(300);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
